// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and operand-forwarding control for a DEPTH-stage post-ID pipeline.
// Tracks in-flight destinations in a shadow shift register and derives stall/flush/freeze/forward selects.
module hazard_fwd_ctrl #(
  parameter int RW         = 4,
  parameter int DEPTH      = 3,
  parameter int LOAD_AVAIL = 2,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_fu_en,
  input  logic             i_id_valid,
  input  logic [RW-1:0]    i_id_src1,
  input  logic             i_id_src1_vld,
  input  logic [RW-1:0]    i_id_src2,
  input  logic             i_id_src2_vld,
  input  logic             i_id_wb_en,
  input  logic             i_id_mem_r_en,
  input  logic [RW-1:0]    i_id_dest,
  input  logic             i_br_taken,
  input  logic             i_mem_busy,
  output logic             o_freeze,
  output logic             o_flush,
  output logic             o_stall,
  output logic             o_bubble,
  output logic [SEL_W-1:0] o_src1_sel,
  output logic [SEL_W-1:0] o_src2_sel,
  output logic [CNT_W-1:0] o_stall_cnt
);

  logic [DEPTH-1:0] r_v, r_wb, r_ld;
  logic [RW-1:0]    r_dst [DEPTH];
  logic [RW-1:0]    r_s1, r_s2;
  logic             r_s1v, r_s2v;
  logic [CNT_W-1:0] r_cnt;

  logic [DEPTH-1:0] w_id_m1, w_id_m2, w_ex_m1, w_ex_m2;
  logic             w_raw1, w_raw2, w_hz, w_stall, w_flush, w_bubble;
  logic [SEL_W-1:0] w_sel1, w_sel2;

  assign w_raw1 = i_id_valid & i_id_src1_vld;
  assign w_raw2 = i_id_valid & i_id_src2_vld;

  always_comb begin
    w_id_m1 = '0;
    w_id_m2 = '0;
    w_ex_m1 = '0;
    w_ex_m2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_id_m1[i] = r_v[i] & r_wb[i] & (r_dst[i] == i_id_src1);
      w_id_m2[i] = r_v[i] & r_wb[i] & (r_dst[i] == i_id_src2);
      w_ex_m1[i] = r_v[i] & r_wb[i] & (r_dst[i] == r_s1);
      w_ex_m2[i] = r_v[i] & r_wb[i] & (r_dst[i] == r_s2);
    end
  end

  // The last stage writes through the register file, so it never needs a stall.
  always_comb begin
    w_hz = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((w_raw1 && w_id_m1[i]) || (w_raw2 && w_id_m2[i])) begin
        if (r_ld[i] && (i + 1 < LOAD_AVAIL)) w_hz = 1'b1;
        if (!i_fu_en && (i <= DEPTH - 2))    w_hz = 1'b1;
      end
    end
  end

  // Scan oldest to youngest so the youngest eligible producer wins.
  always_comb begin
    w_sel1 = '0;
    w_sel2 = '0;
    for (int i = DEPTH - 1; i >= 1; i--) begin
      if (r_s1v && w_ex_m1[i] && (!r_ld[i] || i >= LOAD_AVAIL)) w_sel1 = SEL_W'(i);
      if (r_s2v && w_ex_m2[i] && (!r_ld[i] || i >= LOAD_AVAIL)) w_sel2 = SEL_W'(i);
    end
    if (!i_fu_en) begin
      w_sel1 = '0;
      w_sel2 = '0;
    end
  end

  assign w_flush  = i_br_taken & ~i_mem_busy;
  assign w_stall  = w_hz & ~i_mem_busy & ~i_br_taken;
  assign w_bubble = w_stall | w_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v   <= '0;
      r_wb  <= '0;
      r_ld  <= '0;
      r_s1  <= '0;
      r_s2  <= '0;
      r_s1v <= 1'b0;
      r_s2v <= 1'b0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_dst[i] <= '0;
    end else begin
      if (!i_mem_busy) begin
        r_v  <= {r_v[DEPTH-2:0],  ~w_bubble & i_id_valid};
        r_wb <= {r_wb[DEPTH-2:0], ~w_bubble & i_id_wb_en};
        r_ld <= {r_ld[DEPTH-2:0], ~w_bubble & i_id_mem_r_en};
        for (int i = 1; i < DEPTH; i++) r_dst[i] <= r_dst[i-1];
        r_dst[0] <= i_id_dest;
        r_s1     <= i_id_src1;
        r_s2     <= i_id_src2;
        r_s1v    <= ~w_bubble & i_id_src1_vld;
        r_s2v    <= ~w_bubble & i_id_src2_vld;
      end
      if (w_stall && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_freeze    = i_mem_busy;
  assign o_flush     = w_flush;
  assign o_stall     = w_stall;
  assign o_bubble    = w_bubble;
  assign o_src1_sel  = w_sel1;
  assign o_src2_sel  = w_sel2;
  assign o_stall_cnt = r_cnt;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: a per-cycle vector table plus reset and saturation sequences.
module tb_hazard_fwd_ctrl;

  typedef struct {
    int fu, vld, s1, s1v, s2, s2v, wb, ld, dst, br, busy;
    int frz, fl, st, bu, sel1, sel2, cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       fu_en, id_valid, s1v, s2v, wb_en, mem_r, br, busy;
  logic [3:0] s1, s2, dst;
  logic       freeze, flush, stall, bubble;
  logic [1:0] sel1, sel2;
  logic [15:0] cnt;

  logic       t_valid, t_s1v, t_wb;
  logic [3:0] t_s1, t_dst;
  logic       t_freeze, t_flush, t_stall, t_bubble;
  logic [1:0] t_sel1, t_sel2;
  logic [3:0] t_cnt;

  int n_chk = 0;
  int n_err = 0;
  vec_t tbl[$];

  hazard_fwd_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_fu_en(fu_en), .i_id_valid(id_valid),
    .i_id_src1(s1), .i_id_src1_vld(s1v), .i_id_src2(s2), .i_id_src2_vld(s2v),
    .i_id_wb_en(wb_en), .i_id_mem_r_en(mem_r), .i_id_dest(dst),
    .i_br_taken(br), .i_mem_busy(busy),
    .o_freeze(freeze), .o_flush(flush), .o_stall(stall), .o_bubble(bubble),
    .o_src1_sel(sel1), .o_src2_sel(sel2), .o_stall_cnt(cnt)
  );

  hazard_fwd_ctrl #(.CNT_W(4)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_fu_en(1'b0), .i_id_valid(t_valid),
    .i_id_src1(t_s1), .i_id_src1_vld(t_s1v), .i_id_src2(4'd0), .i_id_src2_vld(1'b0),
    .i_id_wb_en(t_wb), .i_id_mem_r_en(1'b0), .i_id_dest(t_dst),
    .i_br_taken(1'b0), .i_mem_busy(1'b0),
    .o_freeze(t_freeze), .o_flush(t_flush), .o_stall(t_stall), .o_bubble(t_bubble),
    .o_src1_sel(t_sel1), .o_src2_sel(t_sel2), .o_stall_cnt(t_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input vec_t v);
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    fu_en = v.fu[0]; id_valid = v.vld[0]; s1 = 4'(v.s1); s1v = v.s1v[0];
    s2 = 4'(v.s2); s2v = v.s2v[0]; wb_en = v.wb[0]; mem_r = v.ld[0];
    dst = 4'(v.dst); br = v.br[0]; busy = v.busy[0];
  endtask

  task automatic sat_drive(input int v, input int rd, input int wb);
    t_valid = v[0]; t_s1 = 4'd1; t_s1v = rd[0]; t_wb = wb[0]; t_dst = 4'd1;
  endtask

  initial begin
    vec_t idle;
    idle = '{1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0};
    drive(idle);
    sat_drive(0, 0, 0);

    // fu vld s1 s1v s2 s2v wb ld dst br busy | frz fl st bu sel1 sel2 cnt
    add('{1,0,0,0,0,0,0,0,0,0,0,    0,0,0,0,0,0,0});
    add('{1,1,4,1,5,1,1,0,1,0,0,    0,0,0,0,0,0,0});
    add('{1,1,1,1,7,1,1,0,6,0,0,    0,0,0,0,0,0,0});
    add('{0,1,9,1,10,1,1,0,8,0,1,   1,0,0,0,0,0,0});
    add('{1,1,9,1,10,1,1,0,8,0,0,   0,0,0,0,1,0,0});
    add('{1,0,0,0,0,0,0,0,0,0,0,    0,0,0,0,0,0,0});
    add('{1,1,3,1,0,0,1,1,2,0,0,    0,0,0,0,0,0,0});
    add('{1,1,12,1,2,1,1,0,11,0,0,  0,0,1,1,0,0,0});
    add('{1,1,12,1,2,1,1,0,11,0,0,  0,0,0,0,0,0,1});
    add('{1,0,0,0,0,0,0,0,0,0,0,    0,0,0,0,0,2,1});
    add('{1,0,0,0,0,0,0,0,0,0,0,    0,0,0,0,0,0,1});
    add('{0,1,13,1,14,1,1,0,3,0,0,  0,0,0,0,0,0,1});
    add('{0,1,3,1,0,0,1,0,5,0,0,    0,0,1,1,0,0,1});
    add('{0,1,3,1,0,0,1,0,5,0,0,    0,0,1,1,0,0,2});
    add('{0,1,3,1,0,0,1,0,5,0,0,    0,0,0,0,0,0,3});
    add('{1,0,0,0,0,0,0,0,0,0,0,    0,0,0,0,0,0,3});
    add('{1,1,0,0,0,0,1,1,4,0,0,    0,0,0,0,0,0,3});
    add('{1,1,4,1,0,0,1,0,9,1,1,    1,0,0,0,0,0,3});
    add('{1,1,4,1,0,0,1,0,9,1,1,    1,0,0,0,0,0,3});
    add('{1,1,4,1,0,0,1,0,9,1,1,    1,0,0,0,0,0,3});
    add('{1,1,4,1,0,0,1,0,9,0,0,    0,0,1,1,0,0,3});
    add('{0,1,4,1,0,0,1,0,9,1,0,    0,1,0,1,0,0,4});
    add('{1,0,0,0,0,0,0,0,0,0,0,    0,0,0,0,0,0,4});
    add('{1,1,0,0,0,0,1,0,6,0,0,    0,0,0,0,0,0,4});
    add('{1,1,0,0,0,0,1,0,7,0,0,    0,0,0,0,0,0,4});
    add('{1,1,7,1,6,1,1,0,8,0,0,    0,0,0,0,0,0,4});
    add('{1,0,0,0,0,0,0,0,0,0,0,    0,0,0,0,1,2,4});
    add('{1,1,0,0,0,0,1,0,9,0,0,    0,0,0,0,0,0,4});
    add('{1,1,0,0,0,0,1,0,9,0,0,    0,0,0,0,0,0,4});
    add('{1,1,9,1,9,1,0,0,0,0,0,    0,0,0,0,0,0,4});
    add('{1,0,0,0,0,0,0,0,0,0,0,    0,0,0,0,1,1,4});

    #12 rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_sat_cnt", int'(t_cnt), 0);
    chk("rst_sat_stall", int'(t_stall), 0);

    foreach (tbl[k]) begin
      @(negedge clk);
      drive(tbl[k]);
      #1;
      chk($sformatf("v%0d_freeze", k), int'(freeze), tbl[k].frz);
      chk($sformatf("v%0d_flush", k),  int'(flush),  tbl[k].fl);
      chk($sformatf("v%0d_stall", k),  int'(stall),  tbl[k].st);
      chk($sformatf("v%0d_bubble", k), int'(bubble), tbl[k].bu);
      chk($sformatf("v%0d_sel1", k),   int'(sel1),   tbl[k].sel1);
      chk($sformatf("v%0d_sel2", k),   int'(sel2),   tbl[k].sel2);
      chk($sformatf("v%0d_cnt", k),    int'(cnt),    tbl[k].cnt);
    end

    // Reset while a load is in flight must drop the hazard and the count.
    @(negedge clk);
    drive('{1,1,0,0,0,0,1,1,2,0,0, 0,0,0,0,0,0,0});
    @(negedge clk);
    drive('{1,1,0,0,2,1,1,0,5,0,0, 0,0,0,0,0,0,0});
    #1;
    chk("mid_pre_stall", int'(stall), 1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", int'(stall), 0);
    chk("mid_rst_cnt", int'(cnt), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_post_stall", int'(stall), 0);
    chk("mid_post_cnt", int'(cnt), 0);
    drive(idle);

    // Saturation: each round yields exactly two stall cycles on the 4-bit counter.
    for (int r = 0; r < 10; r++) begin
      @(negedge clk);
      sat_drive(1, 0, 1);
      #1;
      chk($sformatf("sat%0d_issue", r), int'(t_stall), 0);
      @(negedge clk);
      sat_drive(1, 1, 0);
      #1;
      chk($sformatf("sat%0d_st_a", r), int'(t_stall), 1);
      @(negedge clk);
      #1;
      chk($sformatf("sat%0d_st_b", r), int'(t_stall), 1);
      @(negedge clk);
      #1;
      chk($sformatf("sat%0d_go", r), int'(t_stall), 0);
      chk($sformatf("sat%0d_cnt", r), int'(t_cnt), (2 * (r + 1) > 15) ? 15 : 2 * (r + 1));
    end
    @(negedge clk);
    sat_drive(0, 0, 0);
    #1;
    chk("sat_final_cnt", int'(t_cnt), 15);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
